// File: rtl/stream_block_max.sv
// stream_block_max: streaming max/argmax over a block of values.
// Values enter lanes-per-beat through a pipelined compare tree.
module stream_block_max #(
    parameter int width       = 8,
    parameter int lanes       = 8,
    parameter int length      = 32,
    parameter int pl_freq     = 1,
    parameter bit signed_mode = 1'b0,
    localparam int IDX_W = ($clog2(length) > 1) ? $clog2(length) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [width-1:0] i_vals [lanes],
    output logic             o_valid,
    input  logic             i_ready,
    output logic [width-1:0] o_max,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_busy
);

    localparam int BEATS = length / lanes;
    localparam int LVLS  = $clog2(lanes);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int NODES = 2 * lanes;

    function automatic logic gt(input logic [width-1:0] a,
                                input logic [width-1:0] b);
        return signed_mode ? ($signed(a) > $signed(b)) : (a > b);
    endfunction

    logic             en;
    logic             acc_beat;
    logic [CNT_W-1:0] cnt;

    // Heap-ordered tree: node n has children 2n and 2n+1, root is node 1,
    // and lane k sits at leaf lanes+k.
    logic [width-1:0] nd_val [1:NODES-1];
    logic [IDX_W-1:0] nd_idx [1:NODES-1];
    logic [LVLS:0]    lv_v;
    logic [LVLS:0]    lv_last;
    logic [LVLS:0]    lv_first;

    assign en       = !(o_valid && !i_ready);
    assign o_ready  = en;
    assign acc_beat = i_valid && en;
    assign o_busy   = (cnt != '0);

    // Beat position within the block; wraps after the last beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (acc_beat) begin
            if (cnt == CNT_W'(BEATS - 1)) cnt <= '0;
            else cnt <= cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < lanes; k++) begin : g_in
        assign nd_val[lanes+k] = i_vals[k];
        assign nd_idx[lanes+k] = IDX_W'(int'(cnt) * lanes + k);
    end

    assign lv_v[0]     = acc_beat;
    assign lv_last[0]  = (cnt == CNT_W'(BEATS - 1));
    assign lv_first[0] = (cnt == '0);

    for (genvar i = 1; i <= LVLS; i++) begin : g_lvl
        localparam int N = lanes >> i;
        logic [width-1:0] c_val [N];
        logic [IDX_W-1:0] c_idx [N];

        for (genvar n = 0; n < N; n++) begin : g_cmp
            logic r_wins;
            // Right child wins only when strictly greater: ties keep lower index.
            assign r_wins   = gt(nd_val[2*(N+n)+1], nd_val[2*(N+n)]);
            assign c_val[n] = r_wins ? nd_val[2*(N+n)+1] : nd_val[2*(N+n)];
            assign c_idx[n] = r_wins ? nd_idx[2*(N+n)+1] : nd_idx[2*(N+n)];
        end

        if (i < LVLS && (i % pl_freq) == 0) begin : g_reg
            logic [width-1:0] r_val [N];
            logic [IDX_W-1:0] r_idx [N];
            logic             r_v;
            logic             r_last;
            logic             r_first;

            // Pipeline stage for this tree level; holds while stalled.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    for (int n = 0; n < N; n++) begin
                        r_val[n] <= '0;
                        r_idx[n] <= '0;
                    end
                    r_v     <= 1'b0;
                    r_last  <= 1'b0;
                    r_first <= 1'b0;
                end else if (en) begin
                    r_val   <= c_val;
                    r_idx   <= c_idx;
                    r_v     <= lv_v[i-1];
                    r_last  <= lv_last[i-1];
                    r_first <= lv_first[i-1];
                end
            end

            for (genvar n = 0; n < N; n++) begin : g_o
                assign nd_val[N+n] = r_val[n];
                assign nd_idx[N+n] = r_idx[n];
            end
            assign lv_v[i]     = r_v;
            assign lv_last[i]  = r_last;
            assign lv_first[i] = r_first;
        end else begin : g_comb
            for (genvar n = 0; n < N; n++) begin : g_o
                assign nd_val[N+n] = c_val[n];
                assign nd_idx[N+n] = c_idx[n];
            end
            assign lv_v[i]     = lv_v[i-1];
            assign lv_last[i]  = lv_last[i-1];
            assign lv_first[i] = lv_first[i-1];
        end
    end

    logic [width-1:0] acc_val;
    logic [IDX_W-1:0] acc_idx;
    logic             take_new;
    logic [width-1:0] cand_val;
    logic [IDX_W-1:0] cand_idx;

    // First beat restarts the block; otherwise an earlier beat keeps ties.
    assign take_new = lv_first[LVLS] || gt(nd_val[1], acc_val);
    assign cand_val = take_new ? nd_val[1] : acc_val;
    assign cand_idx = take_new ? nd_idx[1] : acc_idx;

    // Running block maximum and the output result register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_val <= '0;
            acc_idx <= '0;
            o_valid <= 1'b0;
            o_max   <= '0;
            o_idx   <= '0;
        end else if (en) begin
            o_valid <= lv_v[LVLS] && lv_last[LVLS];
            if (lv_v[LVLS]) begin
                if (lv_last[LVLS]) begin
                    o_max <= cand_val;
                    o_idx <= cand_idx;
                end else begin
                    acc_val <= cand_val;
                    acc_idx <= cand_idx;
                end
            end
        end
    end

endmodule
